// File: rtl/mac_sequencer.sv
// Sequencer for a matrix product C = A*B, one C element at a time, through a single external MAC.
// Each element streams K operand pairs, waits for the MAC pipeline to drain, then offers the result.
module mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int M_DIM      = 4,
    parameter int N_DIM      = 4,
    parameter int K_DIM      = 8,
    localparam int A_AW      = (M_DIM * K_DIM > 1) ? $clog2(M_DIM * K_DIM) : 1,
    localparam int B_AW      = (K_DIM * N_DIM > 1) ? $clog2(K_DIM * N_DIM) : 1,
    localparam int RW        = (M_DIM > 1) ? $clog2(M_DIM) : 1,
    localparam int CW        = (N_DIM > 1) ? $clog2(N_DIM) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    a_rd_en,
    output logic [A_AW-1:0]         a_addr,
    output logic                    b_rd_en,
    output logic [B_AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0]   a_rd_data,
    input  logic [DATA_WIDTH-1:0]   b_rd_data,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    output logic                    mac_load,
    input  logic [2*DATA_WIDTH-1:0] mac_acc,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [2*DATA_WIDTH-1:0] c_data,
    output logic [RW-1:0]           c_row,
    output logic [CW-1:0]           c_col
);

    localparam int KW = $clog2(K_DIM);
    localparam logic [RW-1:0] I_LAST = RW'(M_DIM - 1);
    localparam logic [CW-1:0] J_LAST = CW'(N_DIM - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                  state_q, state_d;
    logic [RW-1:0]           i_q, i_d;
    logic [CW-1:0]           j_q, j_d;
    logic [KW-1:0]           k_q, k_d;
    logic [1:0]              drain_q, drain_d;
    logic [2:0]              load_dly_q, load_dly_d;
    logic [2*DATA_WIDTH-1:0] c_data_q, c_data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            load_dly_q <= '0;
            c_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            load_dly_q <= load_dly_d;
            c_data_q   <= c_data_d;
        end
    end

    // k==0 reaches the accumulator three cycles after issue: one memory cycle plus two MAC stages.
    assign mac_load = load_dly_q[2];
    assign mac_a    = a_rd_data;
    assign mac_b    = b_rd_data;
    assign a_addr   = A_AW'(int'(i_q) * K_DIM + int'(k_q));
    assign b_addr   = B_AW'(int'(k_q) * N_DIM + int'(j_q));
    assign c_data   = c_data_q;
    assign c_row    = i_q;
    assign c_col    = j_q;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        drain_d    = drain_q;
        load_dly_d = {load_dly_q[1:0], (state_q == ISSUE) && (k_q == '0)};
        c_data_d   = c_data_q;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        c_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                a_rd_en = 1'b1;
                b_rd_en = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                // Fourth drain cycle: the last product landed on the previous edge.
                if (drain_q == 2'd3) begin
                    c_data_d = mac_acc;
                    state_d  = RESP;
                end
            end
            RESP: begin
                c_valid = 1'b1;
                if (c_ready) begin
                    if ((i_q == I_LAST) && (j_q == J_LAST)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        state_d = ISSUE;
                        if (j_q == J_LAST) begin
                            j_d = '0;
                            i_d = i_q + RW'(1);
                        end else begin
                            j_d = j_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a 1x1x4 instance for the latency case and a 2x2x2 instance for the rest,
// each with a registered-read memory and a two-stage MAC; results are checked against a plain matrix product.
module tb_mac_sequencer;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance 1: M=N=1, K=4 ----------------
    logic            start1, busy1, done1, a_rd_en1, b_rd_en1, mac_load1, c_valid1, c_ready1;
    logic [1:0]      a_addr1, b_addr1;
    logic [DW-1:0]   a_rd_data1 = '0, b_rd_data1 = '0, mac_a1, mac_b1;
    logic [2*DW-1:0] mac_acc1 = '0, c_data1, p1_1 = '0, p2_1 = '0;
    logic [0:0]      c_row1, c_col1;
    logic signed [DW-1:0] a_mem1 [4];
    logic signed [DW-1:0] b_mem1 [4];
    int rd_cnt1 = 0;

    mac_sequencer #(.DATA_WIDTH(DW), .M_DIM(1), .N_DIM(1), .K_DIM(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .a_rd_en(a_rd_en1), .a_addr(a_addr1), .b_rd_en(b_rd_en1), .b_addr(b_addr1),
        .a_rd_data(a_rd_data1), .b_rd_data(b_rd_data1), .mac_a(mac_a1), .mac_b(mac_b1),
        .mac_load(mac_load1), .mac_acc(mac_acc1), .c_valid(c_valid1), .c_ready(c_ready1),
        .c_data(c_data1), .c_row(c_row1), .c_col(c_col1)
    );

    always @(posedge clk) begin
        if (a_rd_en1) a_rd_data1 <= a_mem1[a_addr1];
        if (b_rd_en1) b_rd_data1 <= b_mem1[b_addr1];
        p1_1     <= $signed(mac_a1) * $signed(mac_b1);
        p2_1     <= p1_1;
        mac_acc1 <= mac_load1 ? p2_1 : mac_acc1 + p2_1;
    end
    always @(negedge clk) if (a_rd_en1) rd_cnt1++;

    // ---------------- instance 2: M=N=K=2 ----------------
    logic            start2, busy2, done2, a_rd_en2, b_rd_en2, mac_load2, c_valid2, c_ready2;
    logic [1:0]      a_addr2, b_addr2;
    logic [DW-1:0]   a_rd_data2 = '0, b_rd_data2 = '0, mac_a2, mac_b2;
    logic [2*DW-1:0] mac_acc2 = '0, c_data2, p1_2 = '0, p2_2 = '0;
    logic [0:0]      c_row2, c_col2;
    logic signed [DW-1:0] a_mem2 [4];
    logic signed [DW-1:0] b_mem2 [4];
    logic [31:0]     exp2 [4];
    logic [31:0]     got_data [4];
    int load_cnt2 = 0;

    mac_sequencer #(.DATA_WIDTH(DW), .M_DIM(2), .N_DIM(2), .K_DIM(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .a_rd_en(a_rd_en2), .a_addr(a_addr2), .b_rd_en(b_rd_en2), .b_addr(b_addr2),
        .a_rd_data(a_rd_data2), .b_rd_data(b_rd_data2), .mac_a(mac_a2), .mac_b(mac_b2),
        .mac_load(mac_load2), .mac_acc(mac_acc2), .c_valid(c_valid2), .c_ready(c_ready2),
        .c_data(c_data2), .c_row(c_row2), .c_col(c_col2)
    );

    always @(posedge clk) begin
        if (a_rd_en2) a_rd_data2 <= a_mem2[a_addr2];
        if (b_rd_en2) b_rd_data2 <= b_mem2[b_addr2];
        p1_2     <= $signed(mac_a2) * $signed(mac_b2);
        p2_2     <= p1_2;
        mac_acc2 <= mac_load2 ? p2_2 : mac_acc2 + p2_2;
    end
    always @(negedge clk) if (mac_load2) load_cnt2++;

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], wrapped to 32 bits.
    task automatic compute_exp2();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'(a_mem2[i*2+k]) * int'(b_mem2[k*2+j]);
                exp2[i*2+j] = 32'(s);
            end
    endtask

    task automatic rand_mats2();
        for (int q = 0; q < 4; q++) begin
            a_mem2[q] = DW'($urandom);
            b_mem2[q] = DW'($urandom);
        end
    endtask

    // One full pass on instance 2; ready_pct sets c_ready density, pulse_start pokes start mid-ISSUE,
    // hold keeps c_ready low for 10 cycles on the first result.
    task automatic run_pass2(input string tag, input int ready_pct, input bit pulse_start, input bit hold);
        int got = 0;
        int cyc = 0;
        int hold_left = hold ? 10 : 0;
        int loads0 = load_cnt2;
        int bad = 0;
        logic [31:0] held = '0;
        compute_exp2();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (got < 4 && cyc < 500) begin
            start2   = (pulse_start && cyc == 1);
            c_ready2 = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
            #1;
            if (hold_left > 0 && c_valid2) begin
                if (hold_left == 10) held = c_data2;
                else check_eq({tag, "_hold_data"}, c_data2, held);
                check_eq({tag, "_hold_valid"}, c_valid2, 1);
                check_eq({tag, "_hold_rd"}, a_rd_en2 | b_rd_en2, 0);
                hold_left--;
            end
            if (c_valid2 && c_ready2) begin
                check_eq({tag, "_row"}, c_row2, got / 2);
                check_eq({tag, "_col"}, c_col2, got % 2);
                check_eq({tag, "_data"}, c_data2, exp2[got]);
                check_eq({tag, "_done"}, done2, (got == 3));
                got_data[got] = c_data2;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        start2   = 1'b0;
        c_ready2 = 1'b0;
        check_eq({tag, "_count"}, got, 4);
        check_eq({tag, "_idle"}, {busy2, done2}, 0);
        check_eq({tag, "_loads"}, load_cnt2 - loads0, 4);
        repeat (20) begin
            @(negedge clk);
            if (busy2 || c_valid2 || done2) bad++;
        end
        check_eq({tag, "_quiet"}, bad, 0);
        $display("pass %s: %0d results in %0d cycles", tag, got, cyc);
    endtask

    initial begin
        int n;
        int bad;
        reset_n  = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        c_ready1 = 1'b1;
        c_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst1_ctl", {busy1, done1, c_valid1, a_rd_en1, b_rd_en1, mac_load1}, 0);
        check_eq("rst1_res", {c_data1, c_row1, c_col1}, 0);
        check_eq("rst2_ctl", {busy2, done2, c_valid2, a_rd_en2, b_rd_en2, mac_load2}, 0);
        check_eq("rst2_res", {c_data2, c_row2, c_col2}, 0);
        reset_n = 1'b1;

        // 1x1 dot product with latency from ISSUE entry
        a_mem1 = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        b_mem1 = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n = 0;
        while (!c_valid1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("dot_latency", n, 8);
        check_eq("dot_data", c_data1, 70);
        check_eq("dot_done", done1, 1);
        check_eq("dot_rowcol", {c_row1, c_col1}, 0);
        @(negedge clk);
        check_eq("dot_after", {busy1, done1, c_valid1}, 0);
        check_eq("dot_reads", rd_cnt1, 4);
        $display("pass dot: latency %0d data %0d", n, c_data1);

        // identity times [[1,2],[3,4]]
        a_mem2 = '{16'sd1, 16'sd0, 16'sd0, 16'sd1};
        b_mem2 = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        run_pass2("ident", 100, 1'b0, 1'b0);
        for (int q = 0; q < 4; q++) check_eq("ident_const", got_data[q], q + 1);

        // negative operands, back-to-back elements
        a_mem2 = '{-16'sd3, 16'sd2, 16'sd4, -16'sd1};
        b_mem2 = '{16'sd5, -16'sd7, -16'sd4, 16'sd6};
        run_pass2("neg", 100, 1'b0, 1'b0);
        check_eq("neg_c00", got_data[0], 32'hFFFF_FFE9);

        rand_mats2();
        run_pass2("backpressure", 100, 1'b0, 1'b1);

        rand_mats2();
        run_pass2("start_ignored", 100, 1'b1, 1'b0);

        // reset while draining the first element
        rand_mats2();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("drain_busy", busy2, 1);
        reset_n = 1'b0;
        #1;
        check_eq("drain_rst_ctl", {busy2, done2, c_valid2, a_rd_en2, b_rd_en2, mac_load2}, 0);
        check_eq("drain_rst_res", {c_data2, c_row2, c_col2}, 0);
        @(negedge clk); reset_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy2 || c_valid2 || done2) bad++;
        end
        check_eq("drain_abandon", bad, 0);
        rand_mats2();
        run_pass2("post_reset", 70, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_mats2();
            run_pass2("random", 60, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand width.
REQ-002 SHALL have parameter M_DIM, default 4: rows of A and of C.
REQ-003 SHALL have parameter N_DIM, default 4: columns of B and of C.
REQ-004 SHALL have parameter K_DIM, default 8, minimum 2: dot-product length (columns of A, rows of B).

Interface
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have clk, input, 1: rising-edge clock.
REQ-007 SHALL have reset_n, input, 1: async active-low reset.
REQ-008 SHALL have start, input, 1: begin one C = A*B pass; sampled only in IDLE.
REQ-009 SHALL have busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have done, output, 1: one-cycle pulse after the last C element is accepted.
REQ-011 SHALL have a_rd_en, output, 1: A-memory read strobe; the A memory returns data one cycle later.
REQ-012 SHALL have a_addr, output, clog2(M_DIM*K_DIM): A address, row-major, i*K_DIM+k.
REQ-013 SHALL have b_rd_en, output, 1: B-memory read strobe; the B memory returns data one cycle later.
REQ-014 SHALL have b_addr, output, clog2(K_DIM*N_DIM): B address, row-major, k*N_DIM+j.
REQ-015 SHALL have a_rd_data and b_rd_data, input, DATA_WIDTH each: memory read data, passed combinationally to mac_a and mac_b.
REQ-016 SHALL have mac_a and mac_b, output, DATA_WIDTH each: MAC operand inputs.
REQ-017 SHALL have mac_load, output, 1: MAC accumulator clear-and-load.
REQ-018 SHALL have mac_acc, input, 2*DATA_WIDTH: MAC accumulator output.
REQ-019 SHALL have c_valid, output, 1; c_ready, input, 1: result handshake.
REQ-020 SHALL have c_data, output, 2*DATA_WIDTH; c_row, output, clog2(M_DIM); c_col, output, clog2(N_DIM): result value and its C index.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, DRAIN and RESP, with done asserted on the RESP->IDLE transition.
REQ-022 SHALL go IDLE->ISSUE on start, with i=0, j=0 and k=0.
REQ-023 SHALL stay in ISSUE for exactly K_DIM cycles, driving a_rd_en=b_rd_en=1 and k=0..K_DIM-1, then go to DRAIN.
REQ-024 SHALL drive a_rd_en and b_rd_en low outside ISSUE.
REQ-025 SHALL model the MAC latency as: operand at mac_a/mac_b in cycle t, its product added into the accumulator at the clock edge ending cycle t+2.
REQ-026 SHALL assert mac_load exactly in the cycle three cycles after k=0 is issued, via a 3-stage delay of (ISSUE && k==0), and deassert it in all other cycles.
REQ-027 SHALL last exactly 4 cycles in DRAIN, with c_data<=mac_acc captured on the fourth cycle (issue of the last k plus 4), then go to RESP.
REQ-028 SHALL hold c_valid=1 in RESP, with c_data, c_row=i and c_col=j stable until c_ready.
REQ-029 SHALL, on c_valid&&c_ready, advance j, wrapping to 0 with i++, and go to ISSUE, or to IDLE with done=1 if i=M_DIM-1 and j=N_DIM-1.
REQ-030 SHALL produce C elements in row-major order; per element, cycles from ISSUE entry to c_valid = K_DIM+4.
REQ-031 SHALL ignore start while busy; start and the final handshake in the same cycle SHALL NOT start a new pass.
REQ-032 SHALL pass c_data unmodified with no saturation; its width and truncation are defined by the MAC.

Reset
REQ-033 SHALL, while reset_n=0, force state=IDLE, i=j=k=0, the load delay line=0, busy=done=c_valid=a_rd_en=b_rd_en=mac_load=0, and c_data=0, c_row=0, c_col=0.
REQ-034 SHALL, on reset mid-pass, abandon the pass with no result emitted and no done; a new start is required.

Verification
REQ-035 Bench SHALL cover: M=N=1, K=4, A=[1,2,3,4], B=[5,6,7,8], c_ready=1 -> c_data=70 at cycle 8 after ISSUE entry, then done pulse.
REQ-036 Bench SHALL cover: M=N=2, K=2, A=I, B=[[1,2],[3,4]] -> c sequence (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4.
REQ-037 Bench SHALL cover: c_ready held 0 for 10 cycles in RESP -> c_valid and c_data stable; no memory reads; one transfer on release.
REQ-038 Bench SHALL cover: start pulsed during ISSUE -> ignored; exactly M*N results.
REQ-039 Bench SHALL cover: reset_n low in DRAIN -> all outputs 0 immediately; a later start yields correct results with no stale accumulation.
REQ-040 Bench SHALL cover: back-to-back elements with negative operands (-3*5 + 2*-4) -> c_data = -23 sign-extended per the MAC, and mac_load high exactly once per element.
